uart_rx_ctrl: RTL



---
 rtl/uart_rx_ctrl.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start qualify, mid-bit sampling, stop check.
// Optional even parity bit when UART_RX_PARITY_EN is defined.
module uart_rx_ctrl #(
  parameter int OSR       = 16,
  parameter int DATA_BITS = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_en,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_busy,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_overrun
);

  localparam int CW = $clog2(OSR + 1);
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [CW-1:0] C_HALF = CW'(OSR / 2);
  localparam logic [CW-1:0] C_FULL = CW'(OSR);
  localparam logic [IW-1:0] I_ONE  = IW'(1);
  localparam logic [IW-1:0] I_LAST = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_WAIT  = 3'd4
`ifdef UART_RX_PARITY_EN
    ,S_PAR  = 3'd5
`endif
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nx;
  logic [CW-1:0]          r_cnt;
  logic [CW-1:0]          w_cnt_inc;
  logic [IW-1:0]          r_idx;
  logic [DATA_BITS-1:0]   r_sh;
  logic [DATA_BITS-1:0]   r_data;
  logic                   r_valid;
  logic                   r_frame_err;
  logic                   r_overrun;

  logic                   w_half;
  logic                   w_full;
  logic                   w_busy;
  logic                   w_stop_smp;
  logic                   w_stop_ok;
  logic                   w_stop_bad;
  logic                   w_deliver;
  logic                   w_load;

`ifdef UART_RX_PARITY_EN
  logic                   r_par_bad;
  logic                   r_parity_err;
`endif

  assign w_cnt_inc = r_cnt + C_ONE;
  assign w_half    = (w_cnt_inc == C_HALF);
  assign w_full    = (w_cnt_inc == C_FULL);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state decode; only ticks move the FSM
  always_comb begin
    w_state_nx = r_state;
    if (i_en) begin
      unique case (r_state)
        S_IDLE: begin
          if (!i_rx) w_state_nx = S_START;
        end
        S_START: begin
          if (i_rx) begin
            w_state_nx = S_IDLE;
          end else if (w_half) begin
            w_state_nx = S_DATA;
          end
        end
        S_DATA: begin
          if (w_full && (r_idx == I_LAST)) begin
`ifdef UART_RX_PARITY_EN
            w_state_nx = S_PAR;
`else
            w_state_nx = S_STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PAR: begin
          if (w_full) w_state_nx = S_STOP;
        end
`endif
        S_STOP: begin
          if (w_full) begin
            w_state_nx = i_rx ? S_IDLE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_rx) w_state_nx = S_IDLE;
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  // Output decode: busy flag and stop-sample qualifiers
  always_comb begin
    w_busy     = (r_state != S_IDLE);
    w_stop_smp = i_en && (r_state == S_STOP) && w_full;
    w_stop_ok  = w_stop_smp && i_rx;
    w_stop_bad = w_stop_smp && !i_rx;
`ifdef UART_RX_PARITY_EN
    w_deliver  = w_stop_ok && !r_par_bad;
`else
    w_deliver  = w_stop_ok;
`endif
    w_load     = w_deliver && (!r_valid || i_ready);
  end

  // Tick counter, bit index and data shifter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_idx <= '0;
      r_sh  <= '0;
    end else if (i_en) begin
      unique case (r_state)
        S_IDLE: begin
          r_cnt <= i_rx ? '0 : C_ONE;
          r_idx <= '0;
        end
        S_START: begin
          r_cnt <= (i_rx || w_half) ? '0 : w_cnt_inc;
          r_idx <= '0;
        end
        S_DATA: begin
          if (w_full) begin
            r_cnt <= '0;
            r_sh  <= {i_rx, r_sh[DATA_BITS-1:1]};
            r_idx <= (r_idx == I_LAST) ? '0 : r_idx + I_ONE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PAR: begin
          r_cnt <= w_full ? '0 : w_cnt_inc;
        end
`endif
        S_STOP: begin
          r_cnt <= w_full ? '0 : w_cnt_inc;
        end
        S_WAIT: begin
          r_cnt <= '0;
        end
        default: begin
          r_cnt <= '0;
          r_idx <= '0;
        end
      endcase
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity mismatch flag, captured at the parity sample
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_par_bad <= 1'b0;
    end else if (i_en) begin
      if (r_state == S_IDLE) begin
        r_par_bad <= 1'b0;
      end else if ((r_state == S_PAR) && w_full) begin
        r_par_bad <= ^{r_sh, i_rx};
      end
    end
  end
`endif

  // Output register, handshake and error pulses (every clock)
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_stop_bad;
      r_overrun   <= w_deliver && r_valid && !i_ready;
      if (w_load) begin
        r_data  <= r_sh;
        r_valid <= 1'b1;
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity error pulse; frame errors suppress it
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= w_stop_ok && r_par_bad;
    end
  end

  assign o_parity_err = r_parity_err;
`else
  assign o_parity_err = 1'b0;
`endif

  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_busy      = w_busy;
  assign o_frame_err = r_frame_err;
  assign o_overrun   = r_overrun;

endmodule
